decoder_rr_arbiter: RTL and testbench
=====================================

// Module: decoder_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-way decoded resource between four requesters.
//  It sequences ownership by registering a 2-bit owner index and its one-hot decode.
//  The decode is enable-gated: all zero when there is no owner.
//  The one-hot grant drives the select lines of the shared resource directly.
//  A per-grant hold limit stops a requester from holding the resource indefinitely.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one grant may be held; 1..255; 0 = no limit
//  CNT_W     8   hold-counter width; must satisfy MAX_HOLD <= 2**CNT_W-1
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous reset, active-high
//  req        in   4  request per requester; level, held high while ownership is wanted
//  gnt        out  4  registered one-hot grant; 4'b0000 when no owner
//  gnt_idx    out  2  registered binary index of owner; valid only when gnt_valid=1
//  gnt_valid  out  1  registered; 1 while any requester owns the resource
//  timeout    out  1  1-cycle pulse when a grant is revoked by the MAX_HOLD limit
// BEHAVIOUR
//  Reset values: gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, state=IDLE,
//   hold_cnt=0, last_idx=2'b11 (requester 0 has top priority after reset).
//  States:
//   IDLE: when req!=0, pick the first asserted requester scanning last_idx+1, +2, +3, +4 (mod 4).
//    Load gnt_idx, gnt=1<<idx, gnt_valid=1, hold_cnt=0. Go to GRANT.
//    When req==0, stay in IDLE with outputs zero.
//   GRANT, release cases (checked each cycle):
//    req[gnt_idx]==0: clear gnt/gnt_valid, last_idx<=gnt_idx, go to IDLE.
//    MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req still high: same as above, plus timeout=1 for one cycle.
//    Otherwise hold_cnt<=hold_cnt+1 and the grant is unchanged.
//  Latency: req rising in cycle N -> gnt visible after edge N+1 (1 cycle).
//   Release is seen on the edge after req drops.
//  Back-to-back: one mandatory idle cycle (gnt=0000) between consecutive grants.
//   This is a guaranteed break-before-make on the select lines.
//  Other requesters changing req during GRANT have no effect on the current owner.
//  After a timeout, the revoked requester has lowest priority.
//   If it keeps req high, it is regranted only after all other active requesters are served.
//  A single requester alone with req held and a timeout: regranted after the idle cycle.
//  gnt is always the one-hot decode of gnt_idx when gnt_valid=1, else 0000.
//   Never more than one bit set.
//  hold_cnt saturates and never wraps. With MAX_HOLD=0 the counter is held at 0.
//  rst overrides everything in any state, mid-grant included.
//   Outputs clear on the next edge and priority returns to requester 0.
//  X on req while in IDLE is not a legal stimulus. The bench holds req known after reset.
// TESTING
//  T1 reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, timeout=0.
//   Release rst -> gnt=0001, gnt_idx=00 one cycle later.
//  T2 rotation, MAX_HOLD=4, req=1111 held -> gnt 0001 for 4 cycles with timeout pulse on release.
//   Then 1 idle cycle, then 0010 x4, 0100 x4, 1000 x4, 0001 again.
//  T3 voluntary release: req=0100 for 3 cycles then 0000 -> gnt=0100 for exactly 3 cycles.
//   Then 0000; timeout stays 0.
//  T4 priority: after grant to idx 2 releases, req=1011 -> gnt=1000 (idx 3).
//   Next arbitration with req=0011 -> gnt=0001.
//  T5 reset mid-grant: gnt=0010 held, assert rst 1 cycle -> gnt=0000 next edge.
//   With req=0011 after reset -> gnt=0001 (priority restored).
//  T6 MAX_HOLD=0, req=0001 held 300 cycles -> gnt=0001 throughout, timeout never asserted.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 4-way decoded resource between four requesters.
// Grants are registered as a 2-bit owner index plus its enable-gated one-hot decode.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? CNT_ZERO : CNT_W'(MAX_HOLD - 1);

    function automatic logic [3:0] decode(input logic [1:0] idx);
        decode = 4'b0001 << idx;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       last_idx_q, last_idx_d;
    logic [1:0]       cand1_s, cand2_s, cand3_s, cand4_s;
    logic [1:0]       pick_idx_s;

    // Rotating priority scan starting just after the previous owner.
    always_comb begin
        cand1_s    = last_idx_q + 2'd1;
        cand2_s    = last_idx_q + 2'd2;
        cand3_s    = last_idx_q + 2'd3;
        cand4_s    = last_idx_q;
        pick_idx_s = req[cand1_s] ? cand1_s :
                     req[cand2_s] ? cand2_s :
                     req[cand3_s] ? cand3_s : cand4_s;
    end

    // Ownership sequencing: grant, hold counting, release and revocation.
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        last_idx_d  = last_idx_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    gnt_idx_d   = pick_idx_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_ZERO;
                    state_d     = GRANT;
                end else begin
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q]) begin
                    gnt_valid_d = 1'b0;
                    last_idx_d  = gnt_idx_q;
                    state_d     = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    gnt_valid_d = 1'b0;
                    last_idx_d  = gnt_idx_q;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // Without a limit the counter stays parked at zero.
                    hold_cnt_d = (MAX_HOLD == 0)        ? CNT_ZERO :
                                 (hold_cnt_q == CNT_MAX) ? hold_cnt_q :
                                                           hold_cnt_q + CNT_ONE;
                end
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        gnt_d = gnt_valid_d ? decode(gnt_idx_d) : 4'b0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'b00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= CNT_ZERO;
            last_idx_q  <= 2'b11;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench: a limited (MAX_HOLD=4) and an unlimited (MAX_HOLD=0) arbiter share
// one stimulus stream; a behavioural owner/queue model predicts every cycle's outputs.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b, tmo_a, tmo_b;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .timeout(tmo_a)
    );

    decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_nolimit (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .timeout(tmo_b)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state per instance: current owner (-1 = none), cycles owned, previous owner.
    int owner[2];
    int held[2];
    int last[2];
    int maxh[2];

    function automatic obs_t model_step(input int k, input logic [3:0] r, input logic rs);
        obs_t o;
        o.tmo = 1'b0;
        if (rs) begin
            owner[k] = -1;
            held[k]  = 0;
            last[k]  = 3;
        end else if (owner[k] < 0) begin
            for (int s = 1; s <= 4; s++) begin
                int i = (last[k] + s) % 4;
                if (owner[k] < 0 && r[i]) begin
                    owner[k] = i;
                    held[k]  = 1;
                end
            end
        end else if (!r[owner[k]]) begin
            last[k]  = owner[k];
            owner[k] = -1;
        end else if (maxh[k] != 0 && held[k] == maxh[k]) begin
            last[k]  = owner[k];
            owner[k] = -1;
            o.tmo    = 1'b1;
        end else begin
            held[k] = held[k] + 1;
        end
        o.valid = (owner[k] >= 0);
        o.gnt   = (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'b0000;
        o.idx   = (owner[k] >= 0) ? 2'(owner[k]) : 2'b00;
        return o;
    endfunction

    task automatic cmp(input string name, input int inst, input logic [3:0] act, input logic [3:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s[inst%0d] t=%0t actual=%b expected=%b", name, inst, $time, act, expv);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rs);
        exp_t e;
        @(posedge clk);
        #2;
        req = r;
        rst = rs;
        e.a = model_step(0, r, rs);
        e.b = model_step(1, r, rs);
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("gnt",       0, gnt_a,          e.a.gnt);
            cmp("gnt_valid", 0, {3'b000, valid_a}, {3'b000, e.a.valid});
            cmp("timeout",   0, {3'b000, tmo_a},   {3'b000, e.a.tmo});
            if (e.a.valid) cmp("gnt_idx", 0, {2'b00, idx_a}, {2'b00, e.a.idx});
            cmp("gnt",       1, gnt_b,          e.b.gnt);
            cmp("gnt_valid", 1, {3'b000, valid_b}, {3'b000, e.b.valid});
            cmp("timeout",   1, {3'b000, tmo_b},   {3'b000, e.b.tmo});
            if (e.b.valid) cmp("gnt_idx", 1, {2'b00, idx_b}, {2'b00, e.b.idx});
        end
    end

    initial begin
        logic [3:0] r;
        int         len;
        maxh[0] = 4;
        maxh[1] = 0;
        owner   = '{-1, -1};
        held    = '{0, 0};
        last    = '{3, 3};

        // Reset with all requests high, then full rotation under the hold limit
        repeat (2) cyc(4'b1111, 1'b1);
        repeat (22) cyc(4'b1111, 1'b0);

        // Voluntary release after three cycles
        cyc(4'b0000, 1'b1);
        repeat (2) cyc(4'b0000, 1'b0);
        repeat (3) cyc(4'b0100, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);

        // Priority rotation after release
        repeat (2) cyc(4'b1011, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);
        repeat (2) cyc(4'b0011, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);

        // Reset in the middle of a grant restores requester 0 priority
        repeat (3) cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b1);
        repeat (2) cyc(4'b0011, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);

        // Long single hold: unlimited instance keeps it, limited one keeps revoking
        repeat (300) cyc(4'b0001, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);

        // Randomized request patterns with occasional resets
        for (int n = 0; n < 120; n++) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                cyc(r, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
            end
        end

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
